altusoc_wb_arbiter: RTL and testbench

ALTUSOC_WB_ARBITER -- requirements
Module: altusoc_wb_arbiter

---
 rtl/altusoc_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_altusoc_wb_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/altusoc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : altusoc_wb_arbiter
// Brief    : Two-master round-robin Wishbone arbiter with bus lock and a
//            per-strobe watchdog that force-terminates a stalled transfer.
// Revision : 1.0
// ============================================================================
module altusoc_wb_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_m0_adr,
    input  logic [31:0] i_m0_dat,
    input  logic [3:0]  i_m0_sel,
    input  logic        i_m0_we,
    input  logic        i_m0_cyc,
    input  logic        i_m0_stb,
    output logic [31:0] o_m0_rdt,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    input  logic [31:0] i_m1_adr,
    input  logic [31:0] i_m1_dat,
    input  logic [3:0]  i_m1_sel,
    input  logic        i_m1_we,
    input  logic        i_m1_cyc,
    input  logic        i_m1_stb,
    output logic [31:0] o_m1_rdt,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_s_adr,
    output logic [31:0] o_s_dat,
    output logic [3:0]  o_s_sel,
    output logic        o_s_we,
    output logic        o_s_cyc,
    output logic        o_s_stb,
    input  logic [31:0] i_s_rdt,
    input  logic        i_s_ack,
    input  logic        i_s_err,
    output logic [1:0]  o_grant,
    output logic        o_timeout
);

    // State encoding doubles as the one-hot grant vector.
    localparam logic [1:0] c_IDLE    = 2'b00;
    localparam logic [1:0] c_GNT0    = 2'b01;
    localparam logic [1:0] c_GNT1    = 2'b10;
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_prio;
    logic       w_prio_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    logic w_gnt0;
    logic w_gnt1;
    logic w_busy;
    logic w_cyc;
    logic w_stb;
    logic w_expire;
    logic w_serr;
    logic w_tmo;

    assign w_gnt0   = (r_state == c_GNT0);
    assign w_gnt1   = (r_state == c_GNT1);
    assign w_busy   = w_gnt0 | w_gnt1;
    assign w_cyc    = (w_gnt0 & i_m0_cyc) | (w_gnt1 & i_m1_cyc);
    assign w_stb    = (w_gnt0 & i_m0_stb) | (w_gnt1 & i_m1_stb);
    // An ack or err landing in the expiry cycle still counts as a normal
    // completion; only a silent slave gets the forced termination.
    assign w_expire = w_busy & (r_cnt == c_TIMEOUT);
    assign w_serr   = w_busy & i_s_err & ~i_s_ack;
    assign w_tmo    = w_expire & ~i_s_ack & ~i_s_err;

    always_comb begin
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_s_we  = 1'b0;
        if (w_gnt0) begin
            o_s_adr = i_m0_adr;
            o_s_dat = i_m0_dat;
            o_s_sel = i_m0_sel;
            o_s_we  = i_m0_we;
        end else if (w_gnt1) begin
            o_s_adr = i_m1_adr;
            o_s_dat = i_m1_dat;
            o_s_sel = i_m1_sel;
            o_s_we  = i_m1_we;
        end
    end

    assign o_s_cyc   = w_cyc & ~w_expire;
    assign o_s_stb   = w_stb & ~w_expire;

    assign o_m0_rdt  = w_gnt0 ? i_s_rdt : '0;
    assign o_m0_ack  = w_gnt0 & i_s_ack;
    assign o_m0_err  = w_gnt0 & (w_serr | w_tmo);
    assign o_m1_rdt  = w_gnt1 ? i_s_rdt : '0;
    assign o_m1_ack  = w_gnt1 & i_s_ack;
    assign o_m1_err  = w_gnt1 & (w_serr | w_tmo);
    assign o_grant   = r_state;
    assign o_timeout = w_tmo;

    assign w_cnt_nxt = (o_s_stb & ~i_s_ack & ~i_s_err) ? (r_cnt + 8'd1) : 8'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            c_IDLE: begin
                if (i_m0_cyc && (!i_m1_cyc || !r_prio)) begin
                    w_state_nxt = c_GNT0;
                end else if (i_m1_cyc) begin
                    w_state_nxt = c_GNT1;
                end
            end
            c_GNT0: begin
                if (w_tmo || !i_m0_cyc) begin
                    w_state_nxt = c_IDLE;
                    w_prio_nxt  = 1'b1;
                end
            end
            c_GNT1: begin
                if (w_tmo || !i_m1_cyc) begin
                    w_state_nxt = c_IDLE;
                    w_prio_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_altusoc_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_altusoc_wb_arbiter
// Brief    : Vector table, scripted arbitration sequences and random traffic
//            checked against a cycle-level behavioural model of the arbiter.
// Revision : 1.0
// ============================================================================
module tb_altusoc_wb_arbiter;

    localparam int TMO = 4;

    typedef struct packed {
        logic [31:0] s_adr;
        logic [31:0] s_dat;
        logic [3:0]  s_sel;
        logic        s_we;
        logic        s_cyc;
        logic        s_stb;
        logic [31:0] m0_rdt;
        logic [31:0] m1_rdt;
        logic        m0_ack;
        logic        m0_err;
        logic        m1_ack;
        logic        m1_err;
        logic [1:0]  grant;
        logic        tmo;
    } obs_t;

    typedef struct {
        bit       rst, c0, s0, c1, s1, ack, err;
        bit [1:0] g;
        bit       scyc, sstb, a0, e0, a1, e1, t;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr [2];
    logic [31:0] dat [2];
    logic [3:0]  sel [2];
    logic        we  [2];
    logic        cyc [2];
    logic        stb [2];
    logic [31:0] s_rdt;
    logic        s_ack, s_err;

    logic [31:0] m0_rdt, m1_rdt, s_adr, s_dat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [3:0]  s_sel;
    logic        s_we, s_cyc, s_stb, tmo;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    // Reference model: current owner (-1 = nobody), preferred master, wait count.
    int own  = -1;
    int pref = 0;
    int wcnt = 0;

    obs_t  got;
    vec_t  tbl [28];
    int    done [2];
    bit    drop [2];
    bit    acked [2];
    int    gap;
    int    m1_acks;
    logic [1:0] prev;
    logic [1:0] segs [$];
    int    gaps [$];

    bit   p_c0 [9] = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    bit   p_c1 [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    bit   p_ak [9] = '{0, 1, 1, 1, 0, 0, 1, 0, 0};
    logic [1:0] p_g [9] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00};

    always #5 clk = ~clk;

    altusoc_wb_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_m0_adr  (adr[0]),
        .i_m0_dat  (dat[0]),
        .i_m0_sel  (sel[0]),
        .i_m0_we   (we[0]),
        .i_m0_cyc  (cyc[0]),
        .i_m0_stb  (stb[0]),
        .o_m0_rdt  (m0_rdt),
        .o_m0_ack  (m0_ack),
        .o_m0_err  (m0_err),
        .i_m1_adr  (adr[1]),
        .i_m1_dat  (dat[1]),
        .i_m1_sel  (sel[1]),
        .i_m1_we   (we[1]),
        .i_m1_cyc  (cyc[1]),
        .i_m1_stb  (stb[1]),
        .o_m1_rdt  (m1_rdt),
        .o_m1_ack  (m1_ack),
        .o_m1_err  (m1_err),
        .o_s_adr   (s_adr),
        .o_s_dat   (s_dat),
        .o_s_sel   (s_sel),
        .o_s_we    (s_we),
        .o_s_cyc   (s_cyc),
        .o_s_stb   (s_stb),
        .i_s_rdt   (s_rdt),
        .i_s_ack   (s_ack),
        .i_s_err   (s_err),
        .o_grant   (grant),
        .o_timeout (tmo)
    );

    function automatic vec_t v(bit r, bit c0, bit s0, bit c1, bit s1, bit a, bit e,
                               bit [1:0] g, bit sc, bit ss, bit a0, bit e0,
                               bit a1, bit e1, bit t);
        vec_t x;
        x.rst = r;  x.c0 = c0; x.s0 = s0; x.c1 = c1; x.s1 = s1; x.ack = a; x.err = e;
        x.g = g;    x.scyc = sc; x.sstb = ss; x.a0 = a0; x.e0 = e0; x.a1 = a1; x.e1 = e1;
        x.t = t;
        return x;
    endfunction

    // What the bus should look like this cycle, from owner/wait-count rules.
    function automatic obs_t model_out();
        obs_t e;
        bit   expire, serr, tfire;
        e      = '0;
        expire = (own >= 0) && (wcnt == TMO);
        serr   = s_err && !s_ack;
        tfire  = expire && !s_ack && !s_err;
        if (own >= 0) begin
            e.grant = (own == 0) ? 2'b01 : 2'b10;
            e.s_adr = adr[own];
            e.s_dat = dat[own];
            e.s_sel = sel[own];
            e.s_we  = we[own];
            e.s_cyc = cyc[own] && !expire;
            e.s_stb = stb[own] && !expire;
            if (own == 0) begin
                e.m0_rdt = s_rdt; e.m0_ack = s_ack; e.m0_err = serr || tfire;
            end else begin
                e.m1_rdt = s_rdt; e.m1_ack = s_ack; e.m1_err = serr || tfire;
            end
        end
        e.tmo = tfire;
        return e;
    endfunction

    task automatic model_step(input obs_t e);
        if (rst) begin
            own = -1; pref = 0; wcnt = 0;
        end else begin
            wcnt = (e.s_stb && !s_ack && !s_err) ? wcnt + 1 : 0;
            if (own < 0) begin
                if (cyc[pref])          own = pref;
                else if (cyc[1 - pref]) own = 1 - pref;
            end else if (e.tmo || !cyc[own]) begin
                pref = 1 - own;
                own  = -1;
            end
        end
    endtask

    // Inputs are already set (1 after the edge); sample mid-cycle, then advance.
    task automatic tick(output obs_t o);
        obs_t e;
        #3;
        o = {s_adr, s_dat, s_sel, s_we, s_cyc, s_stb, m0_rdt, m1_rdt,
             m0_ack, m0_err, m1_ack, m1_err, grant, tmo};
        e = model_out();
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL model cyc %0d: got %h want %h", ncyc, o, e);
        end
        model_step(e);
        @(posedge clk);
        #1;
        ncyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rdt = 32'h0;
        for (int k = 0; k < 2; k++) begin
            adr[k] = '0; dat[k] = '0; sel[k] = '0; we[k] = 1'b0; cyc[k] = 1'b0; stb[k] = 1'b0;
        end
    endtask

    initial begin
        //             rst c0 s0 c1 s1 ak er  grant  sc ss a0 e0 a1 e1 t
        tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = v(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[3]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[4]  = v(0, 1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0);
        tbl[5]  = v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = v(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = v(0, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0);
        tbl[9]  = v(1, 0, 0, 1, 1, 0, 0, 2'b10, 1, 1, 0, 0, 0, 0, 0);
        tbl[10] = v(0, 0, 0, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = v(0, 0, 0, 1, 1, 1, 0, 2'b10, 1, 1, 0, 0, 1, 0, 0);
        tbl[12] = v(0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        tbl[13] = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[14] = v(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[15] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[16] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[17] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[18] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[19] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 0, 0, 0, 1, 0, 0, 1);
        tbl[20] = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[21] = v(0, 1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tbl[22] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[23] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[24] = v(0, 1, 1, 0, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0);
        tbl[25] = v(0, 1, 1, 0, 0, 1, 0, 2'b01, 1, 1, 1, 0, 0, 0, 0);
        tbl[26] = v(0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        tbl[27] = v(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        own = -1; pref = 0; wcnt = 0;

        // Directed vectors: single read, reset during GNT1 wait, timeout, late ack.
        adr[0] = 32'h8000_1000; adr[1] = 32'h4000_2000;
        dat[0] = 32'h1111_2222; dat[1] = 32'h3333_4444;
        sel[0] = 4'hF; sel[1] = 4'h3; we[0] = 1'b0; we[1] = 1'b1;
        s_rdt  = 32'hDEAD_BEEF;
        for (int i = 0; i < 28; i++) begin
            rst = tbl[i].rst; cyc[0] = tbl[i].c0; stb[0] = tbl[i].s0;
            cyc[1] = tbl[i].c1; stb[1] = tbl[i].s1; s_ack = tbl[i].ack; s_err = tbl[i].err;
            tick(got);
            check($sformatf("vec%0d ctrl", i),
                  {55'd0, got.grant, got.s_cyc, got.s_stb, got.m0_ack, got.m0_err,
                   got.m1_ack, got.m1_err, got.tmo},
                  {55'd0, tbl[i].g, tbl[i].scyc, tbl[i].sstb, tbl[i].a0, tbl[i].e0,
                   tbl[i].a1, tbl[i].e1, tbl[i].t});
            check($sformatf("vec%0d rdt", i), {got.m0_rdt, got.m1_rdt},
                  {(tbl[i].g[0] ? 32'hDEAD_BEEF : 32'h0), (tbl[i].g[1] ? 32'hDEAD_BEEF : 32'h0)});
        end

        // Both masters contend from reset, four single transfers each.
        clear_inputs();
        rst = 1'b1;
        tick(got);
        rst = 1'b0;
        done = '{0, 0}; drop = '{0, 0}; gap = 0; prev = 2'b00;
        for (int n = 0; n < 60; n++) begin
            if (done[0] >= 4 && done[1] >= 4 && own < 0) break;
            for (int k = 0; k < 2; k++) begin
                cyc[k] = (done[k] < 4) && !drop[k];
                stb[k] = cyc[k];
            end
            s_ack = (own >= 0) ? cyc[own] : 1'b0;
            for (int k = 0; k < 2; k++) acked[k] = s_ack && (own == k);
            tick(got);
            for (int k = 0; k < 2; k++) begin
                drop[k] = acked[k];
                if (acked[k]) done[k]++;
            end
            if (got.grant == 2'b00) begin
                gap++;
            end else begin
                if (got.grant != prev) begin
                    if (segs.size() > 0) gaps.push_back(gap);
                    segs.push_back(got.grant);
                end
                gap = 0;
            end
            prev = got.grant;
        end
        check("rr segment count", 64'(segs.size()), 64'd8);
        for (int i = 0; i < segs.size() && i < 8; i++)
            check($sformatf("rr owner %0d", i), 64'(segs[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        for (int i = 0; i < gaps.size(); i++)
            check($sformatf("rr gap %0d", i), 64'(gaps[i]), 64'd1);

        // m1 locks the bus for three back-to-back writes while m0 waits.
        clear_inputs();
        rst = 1'b1;
        tick(got);
        rst = 1'b0;
        we[1] = 1'b1; adr[1] = 32'h0000_0040; sel[1] = 4'hF;
        m1_acks = 0;
        for (int i = 0; i < 9; i++) begin
            cyc[0] = p_c0[i]; stb[0] = p_c0[i];
            cyc[1] = p_c1[i]; stb[1] = p_c1[i];
            dat[1] = 32'hA000_0000 + 32'(i);
            s_ack  = p_ak[i];
            tick(got);
            if (got.m1_ack) m1_acks++;
            check($sformatf("lock grant %0d", i), 64'(got.grant), 64'(p_g[i]));
        end
        check("lock m1 acks", 64'(m1_acks), 64'd3);

        // Random traffic against the model.
        clear_inputs();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 127) == 0);
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 3) == 0) cyc[k] = ~cyc[k];
                stb[k] = ($urandom_range(0, 3) != 0);
                adr[k] = $urandom; dat[k] = $urandom;
                sel[k] = 4'($urandom); we[k] = 1'($urandom);
            end
            s_rdt = $urandom;
            s_ack = ($urandom_range(0, 3) == 0);
            s_err = ($urandom_range(0, 15) == 0);
            tick(got);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
